// File: rtl/line_steer_ctrl.sv
`default_nettype none
// ============================================================================
// line_steer_ctrl : IR line pattern -> PD steering -> clamped, slew-limited
//                   left/right servo codes, updated once per servo frame
// Revision 1.0
// ============================================================================
module line_steer_ctrl #(
    parameter int FRAME_CYCLES = 2000000,
    parameter int NEUTRAL      = 75,
    parameter int BASE_SPEED   = 10,
    parameter int KP           = 2,
    parameter int KD           = 1,
    parameter int SERVO_MIN    = 50,
    parameter int SERVO_MAX    = 100,
    parameter int SLEW_MAX     = 4,
    parameter int LOST_FRAMES  = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [4:0]  sensor,
    output logic [10:0] servo_L,
    output logic [10:0] servo_R,
    output logic        upd,
    output logic        lost
);
    localparam int CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int LOST_W = $clog2(LOST_FRAMES + 1);

    localparam logic [CNT_W-1:0]   C_LAST    = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [LOST_W-1:0]  C_LOST    = LOST_W'(LOST_FRAMES);
    localparam logic signed [15:0] C_NEUTRAL = 16'(NEUTRAL);
    localparam logic signed [15:0] C_BASE    = 16'(BASE_SPEED);
    localparam logic signed [15:0] C_KP      = 16'(KP);
    localparam logic signed [15:0] C_KD      = 16'(KD);
    localparam logic signed [15:0] C_MIN     = 16'(SERVO_MIN);
    localparam logic signed [15:0] C_MAX     = 16'(SERVO_MAX);
    localparam logic signed [15:0] C_SLEW    = 16'(SLEW_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_CALC   = 3'd2,
        S_MIX    = 3'd3,
        S_SLEW   = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [4:0]           r_sync1, r_sync2;
    logic signed [3:0]    r_err, r_err_prev, w_err;
    logic signed [4:0]    w_err_sum;
    logic                 r_last_dir;
    logic [LOST_W-1:0]    r_lost_cnt;
    logic signed [15:0]   r_steer, w_steer, w_err16, w_prev16;
    logic signed [15:0]   w_tgt_l, w_tgt_r;
    logic [10:0]          r_servo_l, r_servo_r;
    logic                 r_upd, r_lost;
    logic                 w_tick;

    function automatic logic signed [15:0] f_clamp(input logic signed [15:0] v,
                                                   input logic signed [15:0] lo,
                                                   input logic signed [15:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Step the current code toward the target by at most SLEW_MAX codes.
    function automatic logic [10:0] f_slew(input logic [10:0] cur,
                                           input logic signed [15:0] tgt);
        logic signed [15:0] cur16, step;
        cur16 = $signed({5'b0, cur});
        step  = f_clamp(tgt - cur16, -C_SLEW, C_SLEW);
        return cur + step[10:0];
    endfunction

    assign w_tick = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_tick) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_CALC;
            S_CALC:   w_state_nxt = S_MIX;
            S_MIX:    w_state_nxt = S_SLEW;
            S_SLEW:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_err_sum = (r_sync2[0] ? -5'sd4 : 5'sd0) + (r_sync2[1] ? -5'sd2 : 5'sd0)
                  + (r_sync2[3] ?  5'sd2 : 5'sd0) + (r_sync2[4] ?  5'sd4 : 5'sd0);
        // All dark: steer hard toward the side the line was last seen on.
        if (r_sync2 == 5'b0)           w_err = r_last_dir ? 4'sd6 : -4'sd6;
        else if (w_err_sum > 5'sd6)    w_err = 4'sd6;
        else if (w_err_sum < -5'sd6)   w_err = -4'sd6;
        else                           w_err = w_err_sum[3:0];

        w_err16  = {{12{r_err[3]}}, r_err};
        w_prev16 = {{12{r_err_prev[3]}}, r_err_prev};
        w_steer  = C_KP * w_err16 + C_KD * (w_err16 - w_prev16);

        w_tgt_l = f_clamp(C_NEUTRAL + C_BASE + r_steer, C_MIN, C_MAX);
        w_tgt_r = f_clamp(C_NEUTRAL - C_BASE + r_steer, C_MIN, C_MAX);
        if (!en || (r_lost_cnt == C_LOST)) begin
            w_tgt_l = C_NEUTRAL;
            w_tgt_r = C_NEUTRAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_err      <= '0;
            r_err_prev <= '0;
            r_last_dir <= 1'b0;
            r_lost_cnt <= '0;
            r_steer    <= '0;
            r_servo_l  <= 11'(NEUTRAL);
            r_servo_r  <= 11'(NEUTRAL);
            r_upd      <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
            // New codes are registered at the end of MIX so they are visible
            // together with upd during the SLEW cycle.
            r_upd   <= (r_state == S_MIX);
            case (r_state)
                S_SAMPLE: begin
                    r_err <= w_err;
                    if (r_sync2 == 5'b0) begin
                        if (r_lost_cnt != C_LOST) r_lost_cnt <= r_lost_cnt + LOST_W'(1);
                    end else begin
                        r_lost_cnt <= '0;
                        r_lost     <= 1'b0;
                        if (w_err != 4'sd0) r_last_dir <= (w_err > 4'sd0);
                    end
                end
                S_CALC: begin
                    r_steer    <= w_steer;
                    r_err_prev <= r_err;
                end
                S_MIX: begin
                    r_servo_l <= f_slew(r_servo_l, w_tgt_l);
                    r_servo_r <= f_slew(r_servo_r, w_tgt_r);
                    if (r_lost_cnt == C_LOST) r_lost <= 1'b1;
                    if (!en) begin
                        r_err_prev <= '0;
                        r_lost_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign servo_L = r_servo_l;
    assign servo_R = r_servo_r;
    assign upd     = r_upd;
    assign lost    = r_lost;

endmodule
`default_nettype wire
